// File: rtl/otp_pkg.sv
// Shared definitions for the OTP stream decryptor: default keystream seed,
// LFSR tap mask, FSM state type and the keystream step function.
package otp_pkg;

  localparam logic [15:0] OTP_SEED_DEFAULT = 16'h3327;
  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] OTP_LFSR_TAPS    = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } otp_state_e;

  // Shift left, feed the XOR of the tapped bits into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] k);
    return {k[14:0], ^(k & OTP_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/otp_keystream_lfsr.sv
// Keystream key register.
// Ports: clk/reset (async, active-high); load + load_val store next(load_val);
// adv steps the stored key; key is the current stored key. load wins over adv.
module otp_keystream_lfsr
  import otp_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = OTP_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        adv,
  output logic [15:0] key
);

  logic [15:0] key_q, key_d;

  always_comb begin
    key_d = key_q;
    if (load)     key_d = lfsr_next(load_val);
    else if (adv) key_d = lfsr_next(key_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) key_q <= RESET_VAL;
    else       key_q <= key_d;
  end

  assign key = key_q;

endmodule

// File: rtl/otp_stream_decryptor.sv
// Framed one-time-pad stream decryptor: XORs each ciphertext word with an
// LFSR keystream seeded on the frame-opening (s_sof) word.
// Ports: clk, reset (async, active-high); key_seed/frame_len/passthrough are
// sampled with the opening word; s_valid/s_ready/s_data/s_sof ciphertext in;
// m_valid/m_ready/m_data/m_last plaintext out through one output register;
// word_cnt = words accepted this frame; done/err are one-cycle pulses.
module otp_stream_decryptor
  import otp_pkg::*;
#(
  parameter logic [15:0] SEED_DEFAULT = OTP_SEED_DEFAULT,
  parameter int          LEN_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      key_seed,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             passthrough,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  input  logic             s_sof,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      m_data,
  output logic             m_last,
  output logic [LEN_W-1:0] word_cnt,
  output logic             done,
  output logic             err
);

  otp_state_e       state_q, state_d;
  logic             m_valid_q, m_valid_d;
  logic [15:0]      m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             pass_q, pass_d;

  logic             acc, open_w, cont_w, last_w, cur_pass;
  logic [15:0]      seed_sel, key_reg, cur_key;
  logic [LEN_W-1:0] cur_len, cnt_next;

  always_comb begin
    case (state_q)
      ST_IDLE: s_ready = 1'b1;
      ST_RUN:  s_ready = !m_valid_q || m_ready;
      default: s_ready = 1'b0;
    endcase
  end

  always_comb begin
    acc      = s_valid && s_ready;
    // s_sof always (re)opens a frame; in RUN it also aborts the current one.
    open_w   = acc && s_sof;
    cont_w   = acc && !s_sof && (state_q == ST_RUN);
    err      = acc && (s_sof ? (state_q == ST_RUN) : (state_q == ST_IDLE));
    seed_sel = (key_seed == 16'h0) ? SEED_DEFAULT : key_seed;
    cur_key  = open_w ? seed_sel    : key_reg;
    cur_pass = open_w ? passthrough : pass_q;
    cur_len  = open_w ? frame_len   : len_q;
    // Count wraps, so frame_len 0 matches on word 2^LEN_W.
    cnt_next = open_w ? LEN_W'(1) : word_cnt_q + LEN_W'(1);
    last_w   = (cnt_next == cur_len);

    state_d    = state_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    word_cnt_d = word_cnt_q;
    len_d      = open_w ? frame_len   : len_q;
    pass_d     = open_w ? passthrough : pass_q;

    if (open_w || cont_w) begin
      m_valid_d  = 1'b1;
      m_data_d   = cur_pass ? s_data : (s_data ^ cur_key);
      m_last_d   = last_w;
      word_cnt_d = cnt_next;
      state_d    = last_w ? ST_DRAIN : ST_RUN;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      if (state_q == ST_DRAIN) state_d = ST_IDLE;
    end
  end

  otp_keystream_lfsr #(.RESET_VAL(SEED_DEFAULT)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (open_w),
    .load_val (seed_sel),
    .adv      (cont_w),
    .key      (key_reg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      m_valid_q  <= 1'b0;
      m_data_q   <= 16'h0;
      m_last_q   <= 1'b0;
      word_cnt_q <= '0;
      len_q      <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      pass_q     <= pass_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;
  assign word_cnt = word_cnt_q;
  assign done     = m_valid_q && m_ready && m_last_q;

endmodule

// File: tb/tb_otp_stream_decryptor.sv
module tb_otp_stream_decryptor;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] key_seed;
  logic [7:0]  frame_len;
  logic        passthrough;
  logic        s_valid, s_ready, s_sof;
  logic [15:0] s_data;
  logic        m_valid, m_ready, m_last;
  logic [15:0] m_data;
  logic [7:0]  word_cnt;
  logic        done, err;

  otp_stream_decryptor dut (
    .clk(clk), .reset(reset), .key_seed(key_seed), .frame_len(frame_len),
    .passthrough(passthrough), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .word_cnt(word_cnt), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, last_out_cyc = 0, acc_cyc = 0;
  logic acc_err;
  logic [16:0] expq[$];   // {last, data}

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] nx(input logic [15:0] k);
    return {k[14:0], k[15] ^ k[13] ^ k[12] ^ k[10]};
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (done && !(m_valid && m_ready && m_last)) chk("done_stray", 1, 0);
      if (m_valid && m_ready) begin
        if (expq.size() == 0) chk("unexpected_output", {15'h0, m_last, m_data}, 0);
        else begin
          logic [16:0] e;
          e = expq.pop_front();
          chk("m_data", m_data, e[15:0]);
          chk("m_last", m_last, e[16]);
          chk("done_with_last", done, e[16]);
        end
        if (m_last) last_out_cyc = cyc;
      end
    end
  end

  task automatic push(input logic [15:0] d, input logic l);
    expq.push_back({l, d});
  endtask

  task automatic send(input logic [15:0] d, input logic sof, input logic [15:0] seed,
                      input logic [7:0] len, input logic pass);
    logic got;
    got = 1'b0;
    s_valid = 1'b1; s_data = d; s_sof = sof;
    key_seed = seed; frame_len = len; passthrough = pass;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = s_ready;
      acc_err = err;
      acc_cyc = cyc;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_sof = 1'b0;
    if (!got) chk("send_accept_timeout", 0, 1);
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = (expq.size() == 0) && !m_valid;
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int d0, f0;
    logic [15:0] k;
    reset = 1'b1; key_seed = 0; frame_len = 0; passthrough = 0;
    s_valid = 0; s_data = 0; s_sof = 0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_done_err", {done, err}, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_s_ready", s_ready, 1);

    // Basic frame, seed 3327
    d0 = done_cnt;
    push(16'h3327, 0); push(16'h664E, 1);
    send(16'h0000, 1, 16'h3327, 2, 0);
    send(16'h0000, 0, 16'h3327, 2, 0);
    chk("word_cnt_2", word_cnt, 2);
    drain();
    chk("done_once", done_cnt - d0, 1);

    // Zero seed -> default, frame_len 1 goes straight to DRAIN
    push(16'hCCD8, 1);
    send(16'hFFFF, 1, 16'h0000, 1, 0);
    chk("len1_drain_s_ready", s_ready, 0);
    drain();

    // Passthrough
    push(16'h1234, 0); push(16'h5678, 0); push(16'h9ABC, 1);
    send(16'h1234, 1, 16'h7777, 3, 1);
    send(16'h5678, 0, 16'h7777, 3, 1);
    send(16'h9ABC, 0, 16'h7777, 3, 1);
    drain();

    // Output backpressure mid-frame, seed 1111
    push(16'h1111, 0); push(16'h2223, 0);
    k = nx(nx(16'h1111));
    push(16'hA5A5 ^ k, 0); push(16'h5A5A ^ nx(k), 1);
    send(16'h0000, 1, 16'h1111, 4, 0);
    send(16'h0000, 0, 16'h1111, 4, 0);
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 16'hA5A5;
    repeat (5) begin
      @(negedge clk);
      chk("stall_s_ready", s_ready, 0);
      chk("stall_m_data", {m_valid, m_last, m_data}, {2'b10, 16'h2223});
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    send(16'hA5A5, 0, 16'h1111, 4, 0);
    send(16'h5A5A, 0, 16'h1111, 4, 0);
    drain();

    // 16-word throughput
    k = 16'hACE1;
    for (int i = 0; i < 16; i++) begin
      push(16'(i * 16'h0101) ^ k, i == 15);
      k = nx(k);
    end
    for (int i = 0; i < 16; i++) begin
      send(16'(i * 16'h0101), i == 0, 16'hACE1, 16, 0);
      if (i == 0) f0 = acc_cyc;
    end
    drain();
    chk("run16_cycles", last_out_cyc - f0 + 1, 17);
    chk("run16_word_cnt", word_cnt, 16);

    // Abort: s_sof after 2 of 4 words
    d0 = done_cnt;
    push(16'h5A5A, 0); push(16'hB4B5, 0);
    push(16'h1E1E, 0); push(16'h3C3D, 1);
    send(16'h0000, 1, 16'h5A5A, 4, 0);
    chk("open_no_err", acc_err, 0);
    send(16'h0000, 0, 16'h5A5A, 4, 0);
    send(16'h1111, 1, 16'h0F0F, 2, 0);
    chk("abort_err", acc_err, 1);
    chk("abort_word_cnt", word_cnt, 1);
    send(16'h2222, 0, 16'h0F0F, 2, 0);
    drain();
    chk("abort_done_once", done_cnt - d0, 1);

    // Word without s_sof in IDLE
    send(16'hBEEF, 0, 16'h1234, 2, 0);
    chk("idle_nosof_err", acc_err, 1);
    repeat (3) begin
      @(negedge clk);
      chk("idle_nosof_no_valid", m_valid, 0);
    end

    // Reset mid-frame
    @(posedge clk); #1;
    d0 = done_cnt;
    push(16'h4321, 0);
    send(16'h0000, 1, 16'h4321, 4, 0);
    send(16'h0000, 0, 16'h4321, 4, 0);
    reset = 1'b1;
    #1;
    expq.delete();
    chk("midrst_outputs", {m_valid, m_last, done, err, m_data, word_cnt}, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    send(16'h0001, 0, 16'h4321, 2, 0);
    chk("post_rst_needs_sof", acc_err, 1);
    repeat (2) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("queue_empty", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/otp_stream_decryptor.md
OTP_STREAM_DECRYPTOR -- requirements
Module: otp_stream_decryptor

Interface
REQ-001 Parameter SEED_DEFAULT, 16'h3327, keystream seed substituted when key_seed is zero.
REQ-002 Parameter LEN_W, 8, width of frame_len and word_cnt.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 key_seed  in  16  keystream seed, sampled on the frame-opening word only.
REQ-006 frame_len  in  LEN_W  words per frame, sampled on the frame-opening word; 0 means 2^LEN_W.
REQ-007 passthrough  in  1  bypass XOR for the whole frame, sampled on the frame-opening word.
REQ-008 s_valid / s_ready  in / out  1 / 1  ciphertext handshake.
REQ-009 s_data  in  16  ciphertext word.
REQ-010 s_sof  in  1  marks the first word of a frame.
REQ-011 m_valid / m_ready  out / in  1 / 1  plaintext handshake.
REQ-012 m_data  out  16  plaintext word.
REQ-013 m_last  out  1  marks the final word of a frame.
REQ-014 word_cnt  out  LEN_W  number of words accepted in the current frame.
REQ-015 done  out  1  one-cycle pulse when the last word of a frame is accepted by the sink.
REQ-016 err  out  1  one-cycle pulse on a protocol error.

Function
REQ-017 The input transfer is s_valid&s_ready; the output transfer is m_valid&m_ready.
REQ-018 s_ready SHALL equal (!m_valid | m_ready) in RUN, 1 in IDLE, and 0 in DRAIN.
REQ-019 The single output register SHALL give 1-cycle latency and full throughput with no bubbles.
REQ-020 The keystream LFSR SHALL be next(k) = {k[14:0], k[15]^k[13]^k[12]^k[10]}.
REQ-021 FSM states are IDLE, RUN and DRAIN.
- IDLE -> RUN on a transfer with s_sof = 1.
- RUN -> DRAIN on the transfer that accepts word frame_len.
- DRAIN -> IDLE on the output transfer of the m_last word.
REQ-022 Frame-opening word: key = (key_seed == 0 ? SEED_DEFAULT : key_seed); m_data = s_data ^ key; the stored key becomes next(key).
REQ-023 Each later accepted word: m_data = s_data ^ key_reg, then key_reg <= next(key_reg).
REQ-024 In passthrough, m_data = s_data, while the LFSR and counter still advance identically.
REQ-025 word_cnt SHALL count accepted words and wrap modulo 2^LEN_W; m_last SHALL be set on the word where count == frame_len.
REQ-026 done SHALL pulse in the cycle the m_last word transfers out.
REQ-027 In IDLE, a word with s_sof = 0 SHALL be accepted, discarded (no m_valid) and pulse err.
REQ-028 In RUN, a word with s_sof = 1 SHALL abort the frame and pulse err.
- That same word reopens a new frame per REQ-022 in the same cycle.
- The aborted frame's already-registered word is still delivered, with m_last = 0.
REQ-029 A frame_len of 1 SHALL go IDLE -> DRAIN directly, with m_last set on the first word.
REQ-030 While m_valid is high and m_ready is low, m_data and m_last SHALL be held stable.

Reset
REQ-031 On reset assertion, state = IDLE, key_reg = SEED_DEFAULT, word_cnt = 0, m_valid = 0, m_data = 0, m_last = 0, done = 0, err = 0.
REQ-032 Reset mid-frame SHALL discard the frame and any buffered word immediately; no done pulse results.
REQ-033 The first transfer after reset deassertion requires s_sof.

Structure
REQ-034 A shared package otp_pkg SHALL hold SEED_DEFAULT, the LFSR tap constant, the state enum type and the lfsr_next function.
REQ-035 One sub-module, otp_keystream_lfsr, SHALL provide the key register with load and advance controls.

Verification
REQ-036 Seed 16'h3327, frame_len 2, data 16'h0000, 16'h0000 -> m_data 16'h3327 then 16'h664E; m_last on word 2; done pulse once.
REQ-037 key_seed 0, data 16'hFFFF with s_sof -> m_data 16'hCCD8 (SEED_DEFAULT used).
REQ-038 passthrough 1, frame_len 3, data 16'h1234, 16'h5678, 16'h9ABC -> identical outputs, m_last on 16'h9ABC.
REQ-039 m_ready held 0 for 5 cycles mid-frame -> s_ready 0, m_data stable, no loss; a run of 16 words completes in 17 cycles with m_ready = 1.
REQ-040 s_sof mid-frame, after 2 of 4 words -> err pulse, restart with the new seed, and no done for the aborted frame.
REQ-041 Word without s_sof in IDLE -> err pulse, m_valid stays 0; reset asserted in RUN -> all outputs 0 in the same cycle.
